// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with an occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// selectable first-word-fall-through read mode.
//
// Ports:
//   clk_in       - clock, all state updates on the rising edge
//   reset        - asynchronous active-high reset
//   data_in      - write data (WIDTH)
//   insert       - write request
//   remove       - read request (FWFT: acknowledge the presented word)
//   flush        - synchronous clear, overrides insert/remove
//   data_out     - read data (WIDTH)
//   full/empty   - count == 2^DEPTH / count == 0
//   almost_full  - count >= AF_LEVEL
//   almost_empty - count <= AE_LEVEL
//   count        - occupancy, 0 .. 2^DEPTH (DEPTH+1 bits)
//   overflow     - sticky: insert attempted while full
//   underflow    - sticky: remove attempted while empty
module sync_fifo_prog #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 7,
    parameter int unsigned AF_LEVEL = (1 << DEPTH) - 4,
    parameter int unsigned AE_LEVEL = 4,
    parameter int unsigned FWFT     = 0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             insert,
    input  logic             remove,
    input  logic             flush,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [DEPTH:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned CAP = 1 << DEPTH;
    localparam int unsigned PW  = DEPTH + 1;

    // Threshold legality, reported at elaboration
    if (AF_LEVEL < 1 || AF_LEVEL > CAP) begin : g_bad_af_level
        $error("sync_fifo_prog: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, CAP);
    end
    if (AE_LEVEL > CAP - 1) begin : g_bad_ae_level
        $error("sync_fifo_prog: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, CAP - 1);
    end

    logic [WIDTH-1:0] mem_q [CAP];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             af_q,     af_d;
    logic             ae_q,     ae_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;

    logic             wr_en;
    logic             rd_en;
    logic [DEPTH-1:0] wr_addr;
    logic [DEPTH-1:0] rd_addr;
    logic [DEPTH-1:0] rd_addr_next;

    // Acceptance uses the registered flags only
    assign wr_en        = insert && !full_q;
    assign rd_en        = remove && !empty_q;
    assign wr_addr      = wr_ptr_q[DEPTH-1:0];
    assign rd_addr      = rd_ptr_q[DEPTH-1:0];
    assign rd_addr_next = rd_ptr_d[DEPTH-1:0];

    // Storage: not reset, not cleared by flush
    always_ff @(posedge clk_in) begin
        if (wr_en && !flush && !reset) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    // Next-state for pointers, count, flags and read data
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
            if (insert && full_q)  ovf_d = 1'b1;
            if (remove && empty_q) unf_d = 1'b1;
        end

        if (flush) begin
            data_d = '0;
        end else if (FWFT != 0) begin
            // Present the post-edge head; bypass when the head is the word being written now
            if (count_d == '0) begin
                data_d = '0;
            end else if (wr_en && (wr_addr == rd_addr_next)) begin
                data_d = data_in;
            end else begin
                data_d = mem_q[rd_addr_next];
            end
        end else if (rd_en) begin
            data_d = mem_q[rd_addr];
        end

        full_d  = (count_d == PW'(CAP));
        empty_d = (count_d == '0);
        af_d    = (count_d >= PW'(AF_LEVEL));
        ae_d    = (count_d <= PW'(AE_LEVEL));
    end

    // State registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign data_out     = data_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a standard-read instance (DEPTH=3, WIDTH=8,
// AF_LEVEL=6, AE_LEVEL=2) and an FWFT instance (DEPTH=3, WIDTH=8), each
// checked against a queue-based reference model.
module tb_sync_fifo_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic [7:0] a_din, a_dout;
    logic       a_ins, a_rem, a_fl;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [3:0] a_count;

    logic [7:0] b_din, b_dout;
    logic       b_ins, b_rem, b_fl;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [3:0] b_count;

    int vectors = 0;
    int errors  = 0;

    // Reference model state, standard instance
    logic [7:0] sbq[$];
    logic [7:0] a_exp_data;
    logic       a_exp_ovf, a_exp_unf;

    // Reference model state, FWFT instance
    logic [7:0] fq[$];
    logic       b_exp_ovf, b_exp_unf;

    sync_fifo_prog #(
        .WIDTH(8), .DEPTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)
    ) u_std (
        .clk_in(clk), .reset(rst), .data_in(a_din), .insert(a_ins),
        .remove(a_rem), .flush(a_fl), .data_out(a_dout), .full(a_full),
        .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    sync_fifo_prog #(
        .WIDTH(8), .DEPTH(3), .FWFT(1)
    ) u_fwft (
        .clk_in(clk), .reset(rst), .data_in(b_din), .insert(b_ins),
        .remove(b_rem), .flush(b_fl), .data_out(b_dout), .full(b_full),
        .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag);
        int n;
        n = sbq.size();
        chk({tag, ".count"}, 32'(a_count), 32'(n));
        chk({tag, ".empty"}, 32'(a_empty), 32'(n == 0));
        chk({tag, ".full"},  32'(a_full),  32'(n == 8));
        chk({tag, ".af"},    32'(a_af),    32'(n >= 6));
        chk({tag, ".ae"},    32'(a_ae),    32'(n <= 2));
        chk({tag, ".ovf"},   32'(a_ovf),   32'(a_exp_ovf));
        chk({tag, ".unf"},   32'(a_unf),   32'(a_exp_unf));
        chk({tag, ".data"},  32'(a_dout),  32'(a_exp_data));
    endtask

    task automatic check_b(input string tag);
        int n;
        logic [7:0] head;
        n    = fq.size();
        head = (n > 0) ? fq[0] : 8'h00;
        chk({tag, ".count"}, 32'(b_count), 32'(n));
        chk({tag, ".empty"}, 32'(b_empty), 32'(n == 0));
        chk({tag, ".full"},  32'(b_full),  32'(n == 8));
        chk({tag, ".af"},    32'(b_af),    32'(n >= 4));
        chk({tag, ".ae"},    32'(b_ae),    32'(n <= 4));
        chk({tag, ".ovf"},   32'(b_ovf),   32'(b_exp_ovf));
        chk({tag, ".unf"},   32'(b_unf),   32'(b_exp_unf));
        chk({tag, ".data"},  32'(b_dout),  32'(head));
    endtask

    // One clock of stimulus on the standard instance, then model update and check
    task automatic cyc_a(input logic ins, input logic rem, input logic fl,
                         input logic [7:0] din, input string tag);
        bit wok, rok;
        a_ins = ins; a_rem = rem; a_fl = fl; a_din = din;
        wok = ins && (sbq.size() < 8);
        rok = rem && (sbq.size() > 0);
        step();
        if (fl) begin
            sbq.delete();
            a_exp_data = 8'h00;
            a_exp_ovf  = 1'b0;
            a_exp_unf  = 1'b0;
        end else begin
            if (ins && !wok) a_exp_ovf = 1'b1;
            if (rem && !rok) a_exp_unf = 1'b1;
            if (rok) a_exp_data = sbq.pop_front();
            if (wok) sbq.push_back(din);
        end
        a_ins = 1'b0; a_rem = 1'b0; a_fl = 1'b0;
        check_a(tag);
    endtask

    // One clock of stimulus on the FWFT instance, then model update and check
    task automatic cyc_b(input logic ins, input logic rem,
                         input logic [7:0] din, input string tag);
        bit wok, rok;
        b_ins = ins; b_rem = rem; b_din = din;
        wok = ins && (fq.size() < 8);
        rok = rem && (fq.size() > 0);
        step();
        if (ins && !wok) b_exp_ovf = 1'b1;
        if (rem && !rok) b_exp_unf = 1'b1;
        if (rok) void'(fq.pop_front());
        if (wok) fq.push_back(din);
        b_ins = 1'b0; b_rem = 1'b0;
        check_b(tag);
    endtask

    initial begin
        rst   = 1'b1;
        a_din = '0; a_ins = 1'b0; a_rem = 1'b0; a_fl = 1'b0;
        b_din = '0; b_ins = 1'b0; b_rem = 1'b0; b_fl = 1'b0;
        a_exp_data = 8'h00; a_exp_ovf = 1'b0; a_exp_unf = 1'b0;
        b_exp_ovf  = 1'b0;  b_exp_unf = 1'b0;

        step();
        step();
        check_a("reset_a");
        check_b("reset_b");
        rst = 1'b0;
        step();

        // Fill/drain with threshold tracking and overflow on the 9th insert
        for (int i = 1; i <= 8; i++) cyc_a(1'b1, 1'b0, 1'b0, 8'(i), "fill");
        cyc_a(1'b1, 1'b0, 1'b0, 8'd9, "ovf_ins");
        for (int i = 0; i < 8; i++) cyc_a(1'b0, 1'b1, 1'b0, 8'h00, "drain");
        cyc_a(1'b0, 1'b0, 1'b1, 8'h00, "flush1");

        // Simultaneous insert+remove at count=4
        for (int i = 0; i < 4; i++)  cyc_a(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), "pre4");
        for (int i = 0; i < 10; i++) cyc_a(1'b1, 1'b1, 1'b0, 8'(8'h20 + i), "simul4");

        // Simultaneous at full: count 8 -> 7 with overflow
        for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), "fill8");
        cyc_a(1'b1, 1'b1, 1'b0, 8'h55, "simul_full");
        cyc_a(1'b0, 1'b1, 1'b0, 8'h00, "dec6");
        cyc_a(1'b0, 1'b1, 1'b0, 8'h00, "dec5");

        // Flush with insert+remove at count=5, overflow set; concurrent insert dropped
        cyc_a(1'b1, 1'b1, 1'b1, 8'h66, "flush_ops");
        cyc_a(1'b1, 1'b0, 1'b0, 8'h77, "post_flush_wr");
        cyc_a(1'b0, 1'b1, 1'b0, 8'h00, "post_flush_rd");

        // Simultaneous at empty: count 0 -> 1 with underflow, no read-through
        cyc_a(1'b1, 1'b1, 1'b0, 8'h88, "simul_empty");
        cyc_a(1'b0, 1'b1, 1'b0, 8'h00, "rd88");
        cyc_a(1'b0, 1'b0, 1'b1, 8'h00, "flush2");

        // Pointer wrap: 20 write/read pairs
        for (int i = 0; i < 20; i++) begin
            cyc_a(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i), "wrap_wr");
            cyc_a(1'b0, 1'b1, 1'b0, 8'h00, "wrap_rd");
        end

        // Reset between clock edges at count=3
        for (int i = 0; i < 3; i++) cyc_a(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i), "pre_rst");
        a_ins = 1'b1; a_din = 8'hEE;
        rst   = 1'b1;
        #2;
        chk("async_rst.count", 32'(a_count), 32'd0);
        chk("async_rst.empty", 32'(a_empty), 32'd1);
        chk("async_rst.full",  32'(a_full),  32'd0);
        chk("async_rst.data",  32'(a_dout),  32'd0);
        step();
        a_ins = 1'b0;
        rst   = 1'b0;
        sbq.delete();
        a_exp_data = 8'h00; a_exp_ovf = 1'b0; a_exp_unf = 1'b0;
        step();
        check_a("after_rst");

        // FWFT: first word falls through, remove empties the output
        cyc_b(1'b1, 1'b0, 8'hA5, "fw_wr");
        cyc_b(1'b0, 1'b1, 8'h00, "fw_rd");
        cyc_b(1'b1, 1'b0, 8'h11, "fw_wr11");
        cyc_b(1'b1, 1'b0, 8'h22, "fw_wr22");
        cyc_b(1'b0, 1'b1, 8'h00, "fw_rd11");
        cyc_b(1'b1, 1'b1, 8'h33, "fw_simul1");
        cyc_b(1'b0, 1'b1, 8'h00, "fw_rd33");
        cyc_b(1'b1, 1'b1, 8'h44, "fw_simul_empty");
        cyc_b(1'b0, 1'b1, 8'h00, "fw_rd44");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
